seq_alu: RTL and testbench

Parametrised multi-cycle ALU for the picoMIPS datapath, the next-generation replacement for the fixed 2-bit, 4-function single-cycle ALU. It widens the function code to 3 bits and adds SUB/AND/OR/XOR. It adds a signed radix-2 Booth multiplier with configurable fixed-point scaling and optional saturation. It talks to the controller through a start/busy/done handshake, and the controller stalls the PC while `busy` is high.

---
 rtl/seq_alu.sv | 210 +++++++++++++++++++++
 tb/tb_seq_alu.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// ============================================================================
//  Module   : seq_alu
//  Purpose  : Multi-cycle picoMIPS ALU with radix-2 Booth multiplier,
//             fixed-point scaling and optional saturation.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_alu #(
    parameter int N      = 8,
    parameter int A_SIZE = 3,
    parameter int FRAC   = N - 1,
    parameter int SAT    = 1
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              start,
    input  logic [A_SIZE-1:0] func,
    input  logic [N-1:0]      a,
    input  logic [N-1:0]      b,
    output logic [N-1:0]      result,
    output logic              busy,
    output logic              done,
    output logic              zero,
    output logic              ovf
);

    localparam int CW = $clog2(N + 1);

    localparam logic [A_SIZE-1:0] F_A   = A_SIZE'(0);
    localparam logic [A_SIZE-1:0] F_B   = A_SIZE'(1);
    localparam logic [A_SIZE-1:0] F_ADD = A_SIZE'(2);
    localparam logic [A_SIZE-1:0] F_MUL = A_SIZE'(3);
    localparam logic [A_SIZE-1:0] F_SUB = A_SIZE'(4);
    localparam logic [A_SIZE-1:0] F_AND = A_SIZE'(5);
    localparam logic [A_SIZE-1:0] F_OR  = A_SIZE'(6);
    localparam logic [A_SIZE-1:0] F_XOR = A_SIZE'(7);

    localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MAX_NEG = {1'b1, {(N-1){1'b0}}};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic signed [N:0]   mcand_q, mcand_d;
    logic signed [N:0]   hi_q, hi_d;
    logic [N-1:0]        lo_q, lo_d;
    logic                qm1_q, qm1_d;
    logic [N-1:0]        result_q, result_d;
    logic                done_q, done_d;
    logic                zero_q, zero_d;
    logic                ovf_q, ovf_d;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic signed [N:0]   a_ext, b_ext, sum;
    logic [N-1:0]        alu_res;
    logic                alu_ovf;

    assign a_ext = {a[N-1], a};
    assign b_ext = {b[N-1], b};
    assign sum   = (func == F_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (func)
            F_A:   alu_res = a;
            F_B:   alu_res = b;
            F_ADD, F_SUB: begin
                alu_ovf = sum[N] ^ sum[N-1];
                alu_res = sum[N-1:0];
                // The N+1-bit sign is the true sign, so it picks the clamp rail.
                if (alu_ovf && (SAT != 0)) begin
                    alu_res = sum[N] ? MAX_NEG : MAX_POS;
                end
            end
            F_AND: alu_res = a & b;
            F_OR:  alu_res = a | b;
            F_XOR: alu_res = a ^ b;
            default: alu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Booth step: the upper half carries one guard bit so that the most
    // negative multiplicand can be subtracted without overflow.
    // ------------------------------------------------------------------
    logic signed [N:0]     hi_sum, hi_nx;
    logic [N-1:0]          lo_nx;
    logic                  qm1_nx;
    logic signed [2*N-1:0] prod, scaled;
    logic [N:0]            mul_top;
    logic                  mul_ovf;
    logic [N-1:0]          mul_res;

    always_comb begin
        hi_sum = hi_q;
        case ({lo_q[0], qm1_q})
            2'b01:   hi_sum = hi_q + mcand_q;
            2'b10:   hi_sum = hi_q - mcand_q;
            default: hi_sum = hi_q;
        endcase
        hi_nx  = {hi_sum[N], hi_sum[N:1]};
        lo_nx  = {hi_sum[0], lo_q[N-1:1]};
        qm1_nx = lo_q[0];
    end

    assign prod    = {hi_nx[N-1:0], lo_nx};
    assign scaled  = prod >>> FRAC;
    assign mul_top = scaled[2*N-1:N-1];
    assign mul_ovf = !((&mul_top) || !(|mul_top));

    always_comb begin
        mul_res = scaled[N-1:0];
        if (mul_ovf && (SAT != 0)) begin
            mul_res = scaled[2*N-1] ? MAX_NEG : MAX_POS;
        end
    end

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        qm1_d    = qm1_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (func == F_MUL) begin
                        mcand_d = a_ext;
                        hi_d    = '0;
                        lo_d    = b;
                        qm1_d   = 1'b0;
                        cnt_d   = CW'(N);
                        state_d = S_MUL;
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        done_d   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                // start is deliberately not looked at while the multiply runs.
                hi_d  = hi_nx;
                lo_d  = lo_nx;
                qm1_d = qm1_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = mul_res;
                    zero_d   = (mul_res == '0);
                    ovf_d    = mul_ovf;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            qm1_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            qm1_q    <= qm1_d;
            result_q <= result_d;
            done_q   <= done_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q == S_MUL);
    assign done   = done_q;
    assign zero   = zero_q;
    assign ovf    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
//  Module   : tb_seq_alu
//  Purpose  : Scoreboard bench for seq_alu, saturating and wrapping builds.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_alu;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       nReset;
    logic       start;
    logic [2:0] func;
    logic [7:0] a, b;

    logic [7:0] res_s, res_w;
    logic       busy_s, busy_w, done_s, done_w, zero_s, zero_w, ovf_s, ovf_w;

    int total = 0;
    int bad   = 0;

    logic [9:0] q_s[$];
    logic [9:0] q_w[$];
    logic [9:0] e_s, e_w;

    logic [2:0] rf;
    logic [7:0] ra, rb;

    always #5 clk = ~clk;

    seq_alu #(.N(8), .A_SIZE(3), .FRAC(7), .SAT(1)) u_sat (
        .clk(clk), .nReset(nReset), .start(start), .func(func), .a(a), .b(b),
        .result(res_s), .busy(busy_s), .done(done_s), .zero(zero_s), .ovf(ovf_s)
    );

    seq_alu #(.N(8), .A_SIZE(3), .FRAC(7), .SAT(0)) u_wrap (
        .clk(clk), .nReset(nReset), .start(start), .func(func), .a(a), .b(b),
        .result(res_w), .busy(busy_w), .done(done_w), .zero(zero_w), .ovf(ovf_w)
    );

    // Reference: integer arithmetic on the signed operand values.
    function automatic logic [9:0] model(input logic [2:0] f, input logic [7:0] x,
                                         input logic [7:0] y, input bit sat);
        int sx, sy, s;
        logic [7:0] r;
        logic o;
        sx = int'($signed(x));
        sy = int'($signed(y));
        s  = 0;
        r  = 8'd0;
        o  = 1'b0;
        case (f)
            3'd0: r = x;
            3'd1: r = y;
            3'd5: r = x & y;
            3'd6: r = x | y;
            3'd7: r = x ^ y;
            default: begin
                if (f == 3'd2)      s = sx + sy;
                else if (f == 3'd4) s = sx - sy;
                else                s = (sx * sy) >>> 7;
                r = s[7:0];
                if (s > 127) begin
                    o = 1'b1;
                    if (sat) r = 8'h7F;
                end else if (s < -128) begin
                    o = 1'b1;
                    if (sat) r = 8'h80;
                end
            end
        endcase
        return {r, (r == 8'd0), o};
    endfunction

    // Monitor: every done pulse consumes exactly one expectation.
    always @(posedge clk) begin
        #1;
        if (done_s) begin
            total++;
            if (q_s.size() == 0) begin
                bad++;
                $display("FAIL sat_unexpected_done got r=%h z=%b o=%b want no done", res_s, zero_s, ovf_s);
            end else begin
                e_s = q_s.pop_front();
                if ({res_s, zero_s, ovf_s} !== e_s) begin
                    bad++;
                    $display("FAIL sat_result got r=%h z=%b o=%b want r=%h z=%b o=%b",
                             res_s, zero_s, ovf_s, e_s[9:2], e_s[1], e_s[0]);
                end
            end
        end
        if (done_w) begin
            total++;
            if (q_w.size() == 0) begin
                bad++;
                $display("FAIL wrap_unexpected_done got r=%h z=%b o=%b want no done", res_w, zero_w, ovf_w);
            end else begin
                e_w = q_w.pop_front();
                if ({res_w, zero_w, ovf_w} !== e_w) begin
                    bad++;
                    $display("FAIL wrap_result got r=%h z=%b o=%b want r=%h z=%b o=%b",
                             res_w, zero_w, ovf_w, e_w[9:2], e_w[1], e_w[0]);
                end
            end
        end
    end

    task automatic check_idle(input string name);
        total++;
        if ({res_s, busy_s, done_s, zero_s, ovf_s} !== 12'd0 ||
            {res_w, busy_w, done_w, zero_w, ovf_w} !== 12'd0) begin
            bad++;
            $display("FAIL %s got sat=%h/%b%b%b%b wrap=%h/%b%b%b%b want all zero", name,
                     res_s, busy_s, done_s, zero_s, ovf_s, res_w, busy_w, done_w, zero_w, ovf_w);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is visible.
    task automatic run_op(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y,
                          input bit inject);
        int n;
        int guard;
        n     = 0;
        guard = 0;
        start = 1'b1;
        func  = f;
        a     = x;
        b     = y;
        q_s.push_back(model(f, x, y, 1'b1));
        q_w.push_back(model(f, x, y, 1'b0));
        @(negedge clk);
        start = 1'b0;
        if (f == 3'd3) begin
            while (!done_s && guard < 20) begin
                if (busy_s) n++;
                guard++;
                if (inject && (guard == 2 || guard == 5)) begin
                    start = 1'b1;
                    func  = 3'd2;
                    a     = 8'd1;
                    b     = 8'd1;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
            start = 1'b0;
            total++;
            if (!done_s || busy_s || n != N) begin
                bad++;
                $display("FAIL mul_latency got busy_cycles=%0d done=%b busy=%b want busy_cycles=%0d done=1 busy=0",
                         n, done_s, busy_s, N);
            end
        end else begin
            total++;
            if (!done_s || busy_s) begin
                bad++;
                $display("FAIL op_latency got done=%b busy=%b want done=1 busy=0", done_s, busy_s);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        nReset = 1'b0;
        start  = 1'b0;
        func   = 3'd0;
        a      = 8'd0;
        b      = 8'd0;
        @(negedge clk);
        @(negedge clk);
        check_idle("reset_state");
        nReset = 1'b1;
        @(negedge clk);

        // Directed cases from the operating rules
        run_op(3'd3, 8'h40, 8'h40, 1'b0);
        run_op(3'd3, 8'h80, 8'h80, 1'b0);
        run_op(3'd3, 8'hC0, 8'h40, 1'b0);
        run_op(3'd2, 8'h7F, 8'h01, 1'b0);
        run_op(3'd4, 8'h05, 8'h05, 1'b0);
        run_op(3'd4, 8'h80, 8'h01, 1'b0);
        run_op(3'd5, 8'hF0, 8'h3C, 1'b0);
        run_op(3'd6, 8'hF0, 8'h3C, 1'b0);
        run_op(3'd7, 8'hF0, 8'h3C, 1'b0);
        run_op(3'd0, 8'hA5, 8'h3C, 1'b0);
        run_op(3'd1, 8'hA5, 8'h3C, 1'b0);
        run_op(3'd3, 8'h7F, 8'h81, 1'b1);
        run_op(3'd2, 8'h01, 8'h01, 1'b0);

        // Asynchronous reset between edges with a nonzero result held
        run_op(3'd0, 8'h5A, 8'h00, 1'b0);
        @(posedge clk);
        #3 nReset = 1'b0;
        #1 check_idle("async_reset");
        @(negedge clk);
        nReset = 1'b1;
        @(negedge clk);

        // Reset in the middle of a multiply: no done, nothing pending
        start = 1'b1;
        func  = 3'd3;
        a     = 8'h7F;
        b     = 8'h7F;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #2 nReset = 1'b0;
        #1 check_idle("reset_mid_mul");
        @(negedge clk);
        nReset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("post_reset_idle");
        run_op(3'd3, 8'h20, 8'h20, 1'b0);

        // Randomised back-to-back traffic
        for (int i = 0; i < 60; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(rf, ra, rb, 1'b0);
        end

        repeat (3) @(negedge clk);
        total++;
        if (q_s.size() != 0 || q_w.size() != 0) begin
            bad++;
            $display("FAIL pending_results got sat=%0d wrap=%0d want 0", q_s.size(), q_w.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
